// File: rtl/accelerator_sdiv_40s_10s_32_seq.sv
// accelerator_sdiv_40s_10s_32_seq: radix-2 restoring signed divider, 40s / 10s -> 32s quotient, 10s remainder.
// Define ACCEL_DIV_SAT_EN to saturate the quotient on overflow instead of wrapping.
module accelerator_sdiv_40s_10s_32_seq #(
  parameter int din0_WIDTH = 40,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  overflow
);
  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int DW = dout_WIDTH;
  localparam int CW = $clog2(W0);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [W0-1:0] dvd;
  logic [W1:0] dvs;
  logic [W1-1:0] part;
  logic [CW-1:0] cnt;
  logic sq, sr;
  logic [W0-1:0] a0, qmag, lim;
  logic [W1:0] a1, sh;
  logic ge, ovf;
  logic [DW-1:0] qs, q_out;
  logic [W1-1:0] rs;
  // the dividend magnitude fits W0 bits unsigned; the divisor gets one extra bit so -512 stays 512
  assign a0 = din0[W0-1] ? -din0 : din0;
  assign a1 = din1[W1-1] ? -{1'b1, din1} : {1'b0, din1};
  assign sh = {part, dvd[W0-1]};
  assign ge = sh >= dvs;
  assign qmag = dvd;
  assign lim = W0'(1) << (DW-1);
  assign ovf = sq ? (qmag > lim) : (qmag >= lim);
  assign qs = sq ? -qmag[DW-1:0] : qmag[DW-1:0];
  assign rs = sr ? -part : part;
`ifdef ACCEL_DIV_SAT_EN
  assign q_out = ovf ? (sq ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : qs;
`else
  assign q_out = qs;
`endif
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      dout <= '0;
      rem <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      part <= '0;
      cnt <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd <= a0;
          dvs <= a1;
          part <= '0;
          sq <= din0[W0-1] ^ din1[W1-1];
          sr <= din0[W0-1];
          cnt <= CW'(W0-1);
          in_ready <= 1'b0;
          if (din1 == '0) begin
            state <= DONE;
            out_valid <= 1'b1;
            dout <= '1;
            rem <= din0[W1-1:0];
            div_by_zero <= 1'b1;
            overflow <= 1'b0;
          end else state <= CALC;
        end
        // quotient bits shift into the dividend register as its bits are consumed
        CALC: begin
          part <= ge ? W1'(sh - dvs) : sh[W1-1:0];
          dvd <= {dvd[W0-2:0], ge};
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          dout <= q_out;
          rem <= rs;
          overflow <= ovf;
          div_by_zero <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accelerator_sdiv_40s_10s_32_seq.sv
// tb_accelerator_sdiv_40s_10s_32_seq: directed and random checks against a C-semantics division model.
module tb_accelerator_sdiv_40s_10s_32_seq;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [39:0] din0 = '0;
  logic [9:0] din1 = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] dout;
  logic [9:0] rem;
  logic div_by_zero;
  logic overflow;
  int checks = 0;
  int errors = 0;

  accelerator_sdiv_40s_10s_32_seq dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .rem(rem), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [39:0] a, input logic [9:0] b,
                                output logic [31:0] q, output logic [9:0] r,
                                output logic z, output logic o);
    longint sa, sb, qq, rr;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (sb == 0) begin
      q = '1; r = a[9:0]; z = 1'b1; o = 1'b0;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      z = 1'b0;
      o = (qq > 64'sd2147483647) || (qq < -64'sd2147483648);
      q = qq[31:0];
      r = rr[9:0];
`ifdef ACCEL_DIV_SAT_EN
      if (o) q = (qq > 0) ? 32'h7fffffff : 32'h80000000;
`endif
    end
  endfunction

  task automatic do_op(input logic [39:0] a, input logic [9:0] b, input bit hold);
    int n;
    logic [31:0] eq;
    logic [9:0] er;
    logic ez, eo;
    logic [63:0] junk;
    model(a, b, eq, er, ez, eo);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge ap_clk); n++; end
    check("ready_wait", in_ready, 1);
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    junk = {$urandom, $urandom};
    din0 = junk[39:0]; din1 = junk[49:40];
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!out_valid && n < 100);
    check("valid_wait", out_valid, 1);
    check("latency", 64'(n), (b == 0) ? 64'd1 : 64'd42);
    check("dout", dout, eq);
    check("rem", rem, er);
    check("div_by_zero", div_by_zero, ez);
    check("overflow", overflow, eo);
    check("busy", in_ready, 0);
    if (!hold) begin
      out_ready = 1'b1;
      @(negedge ap_clk);
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("ready_back", in_ready, 1);
    end
  endtask

  initial begin
    logic [31:0] eq;
    logic [9:0] er;
    logic ez, eo;
    logic [63:0] rnd;
    logic signed [39:0] ra;
    logic [9:0] rb;
    bit stale;
    repeat (3) @(negedge ap_clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_rem", rem, 0);
    check("rst_flags", {div_by_zero, overflow}, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    do_op(40'd1000, 10'd7, 0);
    do_op(-40'sd1000, 10'd7, 0);
    do_op(40'd1000, -10'sd7, 0);
    do_op(-40'sd1000, -10'sd512, 0);
    do_op(40'd12345, 10'd0, 0);
    do_op(40'h80_0000_0000, -10'sd1, 0);
    do_op(40'h80_0000_0000, 10'd1, 0);
    do_op(40'h00_8000_0000, 10'd1, 0);
    do_op(40'h00_8000_0000, -10'sd1, 0);
    do_op(-40'sd2147483648, 10'd1, 0);
    do_op(40'h7f_ffff_ffff, -10'sd512, 0);
    do_op(40'd5, 10'd9, 0);
    // backpressure: hold the result while in_valid pulses with other operands
    model(-40'sd777777, 10'd13, eq, er, ez, eo);
    do_op(-40'sd777777, 10'd13, 1);
    for (int i = 0; i < 100; i++) begin
      rnd = {$urandom, $urandom};
      din0 = rnd[39:0]; din1 = rnd[49:40]; in_valid = rnd[60];
      @(negedge ap_clk);
      if (i % 20 == 19) begin
        check("hold_valid", out_valid, 1);
        check("hold_ready", in_ready, 0);
        check("hold_dout", dout, eq);
        check("hold_rem", rem, er);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    check("bp_ready", in_ready, 1);
    check("bp_valid", out_valid, 0);
    do_op(40'd999999, -10'sd100, 0);
    // reset in the middle of CALC
    din0 = 40'd123456; din1 = 10'd11; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (20) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_dout", dout, 0);
    check("abort_rem", rem, 0);
    check("abort_flags", {div_by_zero, overflow}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    stale = 1'b0;
    repeat (60) begin @(negedge ap_clk); if (out_valid) stale = 1'b1; end
    check("stale_valid", stale, 0);
    do_op(40'd100, 10'd3, 0);
    for (int i = 0; i < 30; i++) begin
      rnd = {$urandom, $urandom};
      ra = rnd[39:0];
      ra = ra >>> $urandom_range(0, 39);
      rb = rnd[49:40];
      if ($urandom_range(0, 7) == 0) rb = '0;
      do_op(ra, rb, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
